// File: rtl/stream_mux_pkg.sv
// Shared types and defaults for the stream_mux N:1 valid/ready multiplexer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package stream_mux_pkg;

   // Channel selection policy, sampled every cycle.
   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mux_mode_e;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_NUM_CH = 4;

   // Channel after idx in round-robin order, wrapping from n-1 back to 0.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (with wrap), or the locked channel.
// Latency: purely combinational, no state (ptr/lock live in the parent).
// Backpressure: none; the parent gates the grant with its own load condition.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   input  logic              lock,
   input  logic [SEL_W-1:0]  lock_ch,
   output logic [NUM_CH-1:0] gnt,
   output logic [SEL_W-1:0]  gnt_idx
);

   logic             found;
   logic [SEL_W-1:0] cand;

   // Scan upward from ptr; the first requester wins. A lock pins the grant to lock_ch.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      if (lock) begin
         if (req[lock_ch]) begin
            gnt[lock_ch] = 1'b1;
            gnt_idx      = lock_ch;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cand = SEL_W'((32'(ptr) + 32'(i)) % NUM_CH);
            if (!found && req[cand]) begin
               found     = 1'b1;
               gnt[cand] = 1'b1;
               gnt_idx   = cand;
            end
         end
      end
   end

endmodule

// File: rtl/stream_mux.sv
// N:1 valid/ready stream mux (fixed select or round-robin) with one registered output slot.
// Latency: 1 cycle from input transfer to out_valid/out_data; 1 beat/cycle sustained.
// Backpressure: slot reloads when empty or draining; all in_ready low while stalled. Option: STREAM_MUX_LAST_LOCK_EN.
module stream_mux
   import stream_mux_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  mux_mode_e                     mode,
   input  logic [SEL_W-1:0]              sel,
   input  logic [NUM_CH-1:0][WIDTH-1:0]  in_data,
   input  logic [NUM_CH-1:0]             in_valid,
   output logic [NUM_CH-1:0]             in_ready,
`ifdef STREAM_MUX_LAST_LOCK_EN
   input  logic [NUM_CH-1:0]             in_last,
   output logic                          out_last,
`endif
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SEL_W-1:0]              out_ch
);

   // Output slot and arbitration state.
   logic [WIDTH-1:0]  data_q, data_d;
   logic              vld_q,  vld_d;
   logic [SEL_W-1:0]  ch_q,   ch_d;
   logic [SEL_W-1:0]  ptr_q,  ptr_d;
`ifdef STREAM_MUX_LAST_LOCK_EN
   logic              last_q, last_d;
   logic              lock_q, lock_d;
`endif

   logic              load;
   logic              xfer;
   logic [SEL_W-1:0]  xfer_idx;
   logic [NUM_CH-1:0] rr_gnt;
   logic [SEL_W-1:0]  rr_idx;
   logic              arb_lock;

   // Slot can accept a new beat when empty or when its current beat leaves this cycle.
   assign load = ~vld_q | out_ready;

`ifdef STREAM_MUX_LAST_LOCK_EN
   assign arb_lock = lock_q;
`else
   assign arb_lock = 1'b0;
`endif

   // The lock always follows the channel that produced the last accepted beat.
   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_arb (
      .req     (in_valid),
      .ptr     (ptr_q),
      .lock    (arb_lock),
      .lock_ch (ch_q),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx)
   );

   // Per-channel ready: at most one bit, gated by load, forced low during reset.
   always_comb begin
      in_ready = '0;
      xfer_idx = '0;
      if (!rst) begin
         if (mode == MODE_FIXED) begin
            xfer_idx = sel;
            // An out-of-range select grants nobody rather than aliasing a channel.
            if (32'(sel) < NUM_CH) begin
               in_ready[sel] = load;
            end
         end else begin
            xfer_idx = rr_idx;
            in_ready = rr_gnt & {NUM_CH{load}};
         end
      end
   end

   assign xfer = |(in_valid & in_ready);

   // Next state: capture on transfer, retire on drain, advance the round-robin pointer.
   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      ch_d   = ch_q;
      ptr_d  = ptr_q;
`ifdef STREAM_MUX_LAST_LOCK_EN
      last_d = last_q;
      lock_d = lock_q;
`endif
      if (xfer) begin
         data_d = in_data[xfer_idx];
         ch_d   = xfer_idx;
         vld_d  = 1'b1;
`ifdef STREAM_MUX_LAST_LOCK_EN
         last_d = in_last[xfer_idx];
         // Packets stay on one channel; arbitration resumes only after the last beat.
         if (mode == MODE_RR) begin
            lock_d = ~in_last[xfer_idx];
            if (in_last[xfer_idx]) begin
               ptr_d = SEL_W'(rr_next(32'(xfer_idx), NUM_CH));
            end
         end
`else
         // Fixed-mode traffic leaves the pointer alone so fairness resumes where it left off.
         if (mode == MODE_RR) begin
            ptr_d = SEL_W'(rr_next(32'(xfer_idx), NUM_CH));
         end
`endif
      end else if (vld_q && out_ready) begin
         vld_d = 1'b0;
      end
   end

   // State registers with synchronous reset; a stalled beat is dropped on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         vld_q  <= 1'b0;
         ch_q   <= '0;
         ptr_q  <= '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
         last_q <= 1'b0;
         lock_q <= 1'b0;
`endif
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
         ch_q   <= ch_d;
         ptr_q  <= ptr_d;
`ifdef STREAM_MUX_LAST_LOCK_EN
         last_q <= last_d;
         lock_q <= lock_d;
`endif
      end
   end

   assign out_data  = data_q;
   assign out_valid = vld_q;
   assign out_ch    = ch_q;
`ifdef STREAM_MUX_LAST_LOCK_EN
   assign out_last  = last_q;
`endif

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: fixed select, round-robin, back-pressure, reset, packet lock.
// Latency: expects outputs one clock after each transfer, sampled 1ns after the edge.
// Backpressure: exercises stalls on out_ready and checks in_ready is held low. Option: STREAM_MUX_LAST_LOCK_EN.
`timescale 1ns/1ps
module tb_stream_mux;
   import stream_mux_pkg::*;

   localparam int WIDTH  = 8;
   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   logic                         clk = 1'b0;
   logic                         rst;
   mux_mode_e                    mode;
   logic [SEL_W-1:0]             sel;
   logic [NUM_CH-1:0][WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]            in_valid;
   logic [NUM_CH-1:0]            in_ready;
   logic [WIDTH-1:0]             out_data;
   logic                         out_valid;
   logic                         out_ready;
   logic [SEL_W-1:0]             out_ch;
`ifdef STREAM_MUX_LAST_LOCK_EN
   logic [NUM_CH-1:0]            in_last;
   logic                         out_last;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_mux #(
      .WIDTH  (WIDTH),
      .NUM_CH (NUM_CH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef STREAM_MUX_LAST_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch)
   );

   // Advance to 1ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      mode      = MODE_FIXED;
      sel       = '0;
      in_valid  = '1;
      in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      out_ready = 1'b1;
`ifdef STREAM_MUX_LAST_LOCK_EN
      in_last   = '1;
`endif
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_in_ready_pre: got %b want 0000", in_ready);
      end
      step();
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (out_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_out_data: got %h want 00", out_data);
      end
      checks++;
      if (out_ch !== 2'd0) begin
         errors++;
         $display("FAIL reset_out_ch: got %0d want 0", out_ch);
      end
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 0000", in_ready);
      end
      rst      = 1'b0;
      in_valid = '0;
      step();
   endtask

   task automatic test_fixed();
      logic [7:0] beats [3];
      beats      = '{8'h11, 8'h22, 8'h33};
      mode       = MODE_FIXED;
      sel        = 2'd2;
      out_ready  = 1'b1;
      in_valid   = '1;
      in_data[0] = 8'hE0;
      in_data[1] = 8'hE1;
      in_data[3] = 8'hE3;
      for (int i = 0; i < 3; i++) begin
         in_data[2] = beats[i];
         #1;
         checks++;
         if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_in_ready[%0d]: got %b want 0100", i, in_ready);
         end
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== beats[i]) begin
            errors++;
            $display("FAIL fixed_beat[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, beats[i]);
         end
         checks++;
         if (out_ch !== 2'd2) begin
            errors++;
            $display("FAIL fixed_ch[%0d]: got %0d want 2", i, out_ch);
         end
      end
      in_valid = '0;
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h33) begin
         errors++;
         $display("FAIL fixed_drain: got v=%b d=%h want v=0 d=33", out_valid, out_data);
      end
   endtask

   task automatic test_rr_fair();
      int exp_ch [6];
      exp_ch    = '{0, 1, 2, 3, 0, 1};
      mode      = MODE_RR;
      out_ready = 1'b1;
      in_valid  = '1;
      for (int c = 0; c < NUM_CH; c++) in_data[c] = 8'(c);
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (in_ready !== 4'(1 << exp_ch[i])) begin
            errors++;
            $display("FAIL rr_in_ready[%0d]: got %b want %b", i, in_ready, 4'(1 << exp_ch[i]));
         end
         step();
         checks++;
         if (out_valid !== 1'b1 || out_ch !== 2'(exp_ch[i]) || out_data !== 8'(exp_ch[i])) begin
            errors++;
            $display("FAIL rr_beat[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                     i, out_valid, out_ch, out_data, exp_ch[i], 8'(exp_ch[i]));
         end
      end
      in_valid = '0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rr_drain: got %b want 0", out_valid);
      end
   endtask

   // Pointer is 2 here, so ch3 goes first.
   task automatic test_sparse();
      int exp_ch [4];
      exp_ch     = '{3, 1, 3, 1};
      mode       = MODE_RR;
      out_ready  = 1'b1;
      in_valid   = 4'b1010;
      in_data[1] = 8'h51;
      in_data[3] = 8'h53;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_ch !== 2'(exp_ch[i]) || out_data !== (8'h50 | 8'(exp_ch[i]))) begin
            errors++;
            $display("FAIL sparse_beat[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                     i, out_valid, out_ch, out_data, exp_ch[i], 8'h50 | 8'(exp_ch[i]));
         end
      end
      in_valid = '0;
      step();
   endtask

   task automatic test_backpressure();
      mode       = MODE_FIXED;
      sel        = 2'd1;
      out_ready  = 1'b1;
      in_valid   = 4'b0010;
      in_data[1] = 8'hAA;
      step();
      in_data[1] = 8'hBB;
      out_ready  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, in_ready);
         end
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'hAA || out_ch !== 2'd1) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d want v=1 d=aa ch=1", i, out_valid, out_data, out_ch);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
         errors++;
         $display("FAIL bp_release_ready: got %b want 0010", in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hBB) begin
         errors++;
         $display("FAIL bp_next_beat: got v=%b d=%h want v=1 d=bb", out_valid, out_data);
      end
      in_valid = '0;
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'hBB) begin
         errors++;
         $display("FAIL bp_no_dup: got v=%b d=%h want v=0 d=bb", out_valid, out_data);
      end
   endtask

   // Pointer retention across mode switches, then reset while a beat is stalled.
   task automatic test_mode_switch_and_reset();
      int exp_ch [4];
      mux_mode_e modes [4];
      exp_ch    = '{2, 0, 3, 0};
      modes     = '{MODE_RR, MODE_FIXED, MODE_RR, MODE_RR};
      sel       = 2'd0;
      out_ready = 1'b1;
      in_valid  = '1;
      for (int c = 0; c < NUM_CH; c++) in_data[c] = 8'h60 | 8'(c);
      for (int i = 0; i < 4; i++) begin
         mode = modes[i];
         #1;
         checks++;
         if (in_ready !== 4'(1 << exp_ch[i])) begin
            errors++;
            $display("FAIL switch_in_ready[%0d]: got %b want %b", i, in_ready, 4'(1 << exp_ch[i]));
         end
         step();
         checks++;
         if (out_ch !== 2'(exp_ch[i])) begin
            errors++;
            $display("FAIL switch_ch[%0d]: got %0d want %0d", i, out_ch, exp_ch[i]);
         end
      end
      // ch1 beat then stall it.
      mode = MODE_RR;
      step();
      out_ready = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h61) begin
         errors++;
         $display("FAIL stall_before_reset: got v=%b ch=%0d d=%h want v=1 ch=1 d=61", out_valid, out_ch, out_data);
      end
      rst = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
         errors++;
         $display("FAIL midstall_reset: got v=%b d=%h ch=%0d want v=0 d=00 ch=0", out_valid, out_data, out_ch);
      end
      rst       = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++;
         $display("FAIL post_reset_ptr: got in_ready %b want 0001", in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h60) begin
         errors++;
         $display("FAIL post_reset_beat: got v=%b ch=%0d d=%h want v=1 ch=0 d=60", out_valid, out_ch, out_data);
      end
      in_valid = '0;
      step();
   endtask

`ifdef STREAM_MUX_LAST_LOCK_EN
   task automatic test_lock();
      logic [7:0] beats [3];
      beats     = '{8'hC1, 8'hC2, 8'hC3};
      rst       = 1'b1;
      in_valid  = '0;
      step();
      rst        = 1'b0;
      mode       = MODE_RR;
      out_ready  = 1'b1;
      in_valid   = 4'b0011;
      in_data[1] = 8'hD1;
      in_last    = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         in_data[0] = beats[i];
         in_last[0] = (i == 2);
         #1;
         checks++;
         if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL lock_in_ready[%0d]: got %b want 0001", i, in_ready);
         end
         step();
         checks++;
         if (out_ch !== 2'd0 || out_data !== beats[i] || out_last !== (i == 2)) begin
            errors++;
            $display("FAIL lock_beat[%0d]: got ch=%0d d=%h last=%b want ch=0 d=%h last=%b",
                     i, out_ch, out_data, out_last, beats[i], (i == 2));
         end
      end
      in_valid = 4'b0010;
      step();
      checks++;
      if (out_ch !== 2'd1 || out_data !== 8'hD1 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL lock_release: got ch=%0d d=%h last=%b want ch=1 d=d1 last=1", out_ch, out_data, out_last);
      end
      in_valid = '0;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_fixed();
      test_rr_fair();
      test_sparse();
      test_backpressure();
      test_mode_switch_and_reset();
`ifdef STREAM_MUX_LAST_LOCK_EN
      test_lock();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within 200000 ns");
      $fatal(1);
   end

endmodule
